// File: rtl/cond_logic.sv
// cond_logic: conditional-execution unit of the ARM-subset CPU controller.
// Holds the NZCV status flags and checks each instruction's condition field
// against them. PC, register, memory and flag writes happen only when the
// condition holds.
// Optional build macro CONDLOGIC_DEBUG_EN adds the Flags and CondEx trace
// outputs. Without it, only the base ports exist.
module cond_logic #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite
`ifdef CONDLOGIC_DEBUG_EN
  ,
  output logic [3:0] Flags,
  output logic       CondEx
`endif
);

  // Stored flags, kept as two halves that are written independently.
  logic [1:0] flags_nz;   // {N,Z}
  logic [1:0] flags_cv;   // {C,V}
  logic       n_flag, z_flag, c_flag, v_flag;
  logic       cond_ex;
  logic       write_nz, write_cv;

  assign n_flag = flags_nz[1];
  assign z_flag = flags_nz[0];
  assign c_flag = flags_cv[1];
  assign v_flag = flags_cv[0];

  // Decode all 16 condition codes against the stored flags (never ALUFlags).
  always_comb begin
    cond_ex = 1'b1;
    case (Cond)
      4'b0000: cond_ex = z_flag;                              // EQ
      4'b0001: cond_ex = ~z_flag;                             // NE
      4'b0010: cond_ex = c_flag;                              // CS
      4'b0011: cond_ex = ~c_flag;                             // CC
      4'b0100: cond_ex = n_flag;                              // MI
      4'b0101: cond_ex = ~n_flag;                             // PL
      4'b0110: cond_ex = v_flag;                              // VS
      4'b0111: cond_ex = ~v_flag;                             // VC
      4'b1000: cond_ex = c_flag & ~z_flag;                    // HI
      4'b1001: cond_ex = ~c_flag | z_flag;                    // LS
      4'b1010: cond_ex = (n_flag == v_flag);                  // GE
      4'b1011: cond_ex = (n_flag != v_flag);                  // LT
      4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);        // GT
      4'b1101: cond_ex = z_flag | (n_flag != v_flag);         // LE
      4'b1110: cond_ex = 1'b1;                                // AL
      default: cond_ex = 1'b1;                                // 1111 acts as AL
    endcase
  end

  // A failed condition suppresses every side effect, including flag writes.
  // Reset does not force these outputs low.
  assign write_nz = FlagW[1] & cond_ex;
  assign write_cv = FlagW[0] & cond_ex;
  assign PCSrc    = PCS  & cond_ex;
  assign RegWrite = RegW & cond_ex;
  assign MemWrite = MemW & cond_ex;

  // Flag register. Reset wins over any write on the same edge. The write
  // enable comes from the old flags, so there is no same-cycle bypass.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      flags_nz <= FLAG_RESET[3:2];
      flags_cv <= FLAG_RESET[1:0];
    end else begin
      if (write_nz) flags_nz <= ALUFlags[3:2];
      if (write_cv) flags_cv <= ALUFlags[1:0];
    end
  end

`ifdef CONDLOGIC_DEBUG_EN
  assign Flags  = {flags_nz, flags_cv};
  assign CondEx = cond_ex;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: bench for cond_logic in its default build. The bench has no
// direct view of the stored flags. It reads them back through the
// EQ/CS/MI/VS conditions instead.
module tb_cond_logic;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW;
  logic       PCSrc, RegWrite, MemWrite;

  int pass_cnt = 0;
  int total_cnt = 0;

  cond_logic #(.FLAG_RESET(4'b0000)) dut (
    .CLK(CLK), .Reset(Reset), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite)
  );

  // Clock and a hard time limit.
  always #5 CLK = ~CLK;
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0] flags;   // NZCV to preload
    logic [3:0] cond;
    logic [2:0] req;     // {PCS,RegW,MemW}
    logic [2:0] exp;     // {PCSrc,RegWrite,MemWrite}
  } vec_t;

  vec_t vecs[17];

  // Reference model: stored flags plus a condition evaluator. The evaluator
  // uses ARM's rule that cond[0] inverts the base test of the pair.
  logic [3:0] m_flags;

  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return base ^ c[0];
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Reset = 1'b0; Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
  endtask

  // Write all four flags through an AL instruction.
  task automatic load_flags(input logic [3:0] f);
    Reset = 1'b0; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    tick();
    FlagW = 2'b00;
  endtask

  // Read the stored flags back through RegWrite under EQ, CS, MI and VS.
  task automatic probe_flags(input string name, input logic [3:0] exp);
    logic [3:0] got;
    FlagW = 2'b00; PCS = 1'b0; MemW = 1'b0; RegW = 1'b1;
    Cond = 4'b0100; #1; got[3] = RegWrite;
    Cond = 4'b0000; #1; got[2] = RegWrite;
    Cond = 4'b0010; #1; got[1] = RegWrite;
    Cond = 4'b0110; #1; got[0] = RegWrite;
    check(name, got, exp);
  endtask

  task automatic cond_check(input string name, input logic [3:0] c, input logic exp);
    Cond = c; RegW = 1'b1; #1;
    check(name, {3'b000, RegWrite}, {3'b000, exp});
  endtask

  initial begin
    logic [2:0] outs;
    logic       e;

    // Hand-computed table: each row preloads flags, then applies a condition.
    vecs[0]  = '{4'b0100, 4'b0000, 3'b111, 3'b111}; // EQ, Z=1
    vecs[1]  = '{4'b0100, 4'b0001, 3'b111, 3'b000}; // NE
    vecs[2]  = '{4'b0010, 4'b0010, 3'b101, 3'b101}; // CS
    vecs[3]  = '{4'b0010, 4'b0011, 3'b111, 3'b000}; // CC
    vecs[4]  = '{4'b1000, 4'b0100, 3'b010, 3'b010}; // MI
    vecs[5]  = '{4'b1000, 4'b0101, 3'b111, 3'b000}; // PL
    vecs[6]  = '{4'b0001, 4'b0110, 3'b110, 3'b110}; // VS
    vecs[7]  = '{4'b0001, 4'b0111, 3'b111, 3'b000}; // VC
    vecs[8]  = '{4'b0010, 4'b1000, 3'b111, 3'b111}; // HI, C=1 Z=0
    vecs[9]  = '{4'b0110, 4'b1000, 3'b111, 3'b000}; // HI, Z=1
    vecs[10] = '{4'b0110, 4'b1001, 3'b011, 3'b011}; // LS
    vecs[11] = '{4'b1001, 4'b1010, 3'b111, 3'b111}; // GE, N=V=1
    vecs[12] = '{4'b1000, 4'b1011, 3'b100, 3'b100}; // LT, N!=V
    vecs[13] = '{4'b0100, 4'b1100, 3'b111, 3'b000}; // GT, Z=1
    vecs[14] = '{4'b0000, 4'b1101, 3'b111, 3'b000}; // LE, Z=0 N==V
    vecs[15] = '{4'b1111, 4'b1110, 3'b001, 3'b001}; // AL
    vecs[16] = '{4'b0000, 4'b1111, 3'b111, 3'b111}; // 1111 as always

    idle();

    // Reset, then AL.
    Reset = 1'b1; Cond = 4'b1110; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
    tick(); tick();
    Reset = 1'b0; #1;
    check("reset_al", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0111);
    Cond = 4'b0000; #1;
    check("reset_eq", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    probe_flags("reset_flags", 4'b0000);

    // Flag write, then EQ/NE.
    PCS = 1'b0; MemW = 1'b0;
    load_flags(4'b0100);
    cond_check("fw_eq", 4'b0000, 1'b1);
    cond_check("fw_ne", 4'b0001, 1'b0);

    // Partial write of C,V only.
    Reset = 1'b1; tick(); Reset = 1'b0;
    Cond = 4'b1110; FlagW = 2'b01; ALUFlags = 4'b1111; tick();
    probe_flags("partial_flags", 4'b0011);
    cond_check("partial_cs", 4'b0010, 1'b1);
    cond_check("partial_mi", 4'b0100, 1'b0);

    // A failed condition blocks the flag write and gated outputs.
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111; PCS = 1'b1; MemW = 1'b1; RegW = 1'b0;
    #1;
    check("fail_gate", {2'b00, PCSrc, MemWrite}, 4'b0000);
    tick();
    probe_flags("fail_noflag", 4'b0011);

    // Signed and unsigned compares.
    load_flags(4'b1000);
    cond_check("ge_n1v0", 4'b1010, 1'b0);
    cond_check("lt_n1v0", 4'b1011, 1'b1);
    cond_check("gt_n1v0", 4'b1100, 1'b0);
    cond_check("le_n1v0", 4'b1101, 1'b1);
    load_flags(4'b1001);
    cond_check("ge_n1v1", 4'b1010, 1'b1);
    cond_check("gt_n1v1", 4'b1100, 1'b1);
    cond_check("le_n1v1", 4'b1101, 1'b0);
    load_flags(4'b0010);
    cond_check("hi_c1z0", 4'b1000, 1'b1);
    cond_check("ls_c1z0", 4'b1001, 1'b0);

    // Reset takes priority over a flag write on the same edge.
    Reset = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
    tick();
    Reset = 1'b0; FlagW = 2'b00;
    probe_flags("rst_prio_flags", 4'b0000);
    cond_check("cond_1111", 4'b1111, 1'b1);

    // Table-driven vectors.
    for (int i = 0; i < 17; i++) begin
      load_flags(vecs[i].flags);
      Cond = vecs[i].cond;
      {PCS, RegW, MemW} = vecs[i].req;
      #1;
      check($sformatf("vec%0d", i), {1'b0, PCSrc, RegWrite, MemWrite}, {1'b0, vecs[i].exp});
    end

    // Randomized run against the reference model.
    idle();
    Reset = 1'b1; tick();
    m_flags = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      Reset    = ($urandom_range(0, 15) == 0);
      Cond     = 4'($urandom_range(0, 15));
      ALUFlags = 4'($urandom_range(0, 15));
      FlagW    = 2'($urandom_range(0, 3));
      {PCS, RegW, MemW} = 3'($urandom_range(0, 7));
      #1;
      e = model_cond(Cond, m_flags);
      outs = {PCS, RegW, MemW} & {3{e}};
      check($sformatf("rand%0d", i), {1'b0, PCSrc, RegWrite, MemWrite}, {1'b0, outs});
      if (Reset) m_flags = 4'b0000;
      else begin
        if (FlagW[1] && e) m_flags[3:2] = ALUFlags[3:2];
        if (FlagW[0] && e) m_flags[1:0] = ALUFlags[1:0];
      end
      tick();
    end
    idle();
    probe_flags("rand_final_flags", m_flags);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
Conditional-execution unit of the ARM-subset CPU controller. Holds the processor NZCV status flags and evaluates the instruction's 4-bit condition field against the stored flags. Gates the decoder's PC-source, register-write and memory-write requests and the flag-register writes with the condition result. Sits between the main decoder and the datapath/PC mux.

Parameters:
FLAG_RESET, 4'b0000, value loaded into the stored NZCV flags on reset.

Ports:
CLK  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Cond  input  4  instruction condition field (Instr[31:28])
ALUFlags  input  4  ALU result flags {N,Z,C,V}, bit 3 = N
FlagW  input  2  flag-write request; [1] = update N,Z; [0] = update C,V
PCS  input  1  decoder request to write PC (branch or write to R15)
RegW  input  1  decoder register-write request
MemW  input  1  decoder memory-write request
PCSrc  output  1  PCS gated by the condition result
RegWrite  output  1  RegW gated by the condition result
MemWrite  output  1  MemW gated by the condition result

Behaviour:
- State: 4-bit Flags register {N,Z,C,V}, split into two independently enabled halves, Flags[3:2] (N,Z) and Flags[1:0] (C,V).
- Reset, sampled on the rising edge of CLK: Flags <= FLAG_RESET. Reset takes priority over any FlagW update in the same cycle.
- CondEx is combinational and is evaluated from the currently stored Flags, not from ALUFlags.
- Condition table (N,Z,C,V are the stored values):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C & ~Z
  - 1001 LS: ~C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: ~Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 1 (treated as always)
- Gated outputs are combinational with zero latency: PCSrc = PCS & CondEx; RegWrite = RegW & CondEx; MemWrite = MemW & CondEx.
- Outputs are not forced low by Reset; they follow the formulas above using the stored flags.
- Flag update on the rising edge when Reset = 0:
  - if FlagW[1] & CondEx: Flags[3:2] <= ALUFlags[3:2]
  - if FlagW[0] & CondEx: Flags[1:0] <= ALUFlags[1:0]
  - otherwise each half holds its value.
- The CondEx that enables a flag write is computed from the old flags. The new flags affect CondEx only from the next cycle, so there is no same-cycle bypass.
- A failed condition suppresses all side effects: no register, memory, PC or flag writes.
- There are no X-propagation paths: all 16 Cond codes are fully decoded.

Optional Feature:
CONDLOGIC_DEBUG_EN
- Defined: adds two outputs, Flags (output, 4 bits, stored NZCV) and CondEx (output, 1 bit, raw condition result), for trace and waveform visibility. Functional behaviour is unchanged.
- Undefined: these ports and their logic are absent. Only the ports listed above exist.

Test Plan:
- Reset then AL:
  - Stimulus: assert Reset for 2 cycles, release; Cond=1110, PCS=1, RegW=1, MemW=1.
  - Response: PCSrc=1, RegWrite=1, MemWrite=1 combinationally.
  - Stimulus: Cond=0000.
  - Response: all three outputs 0, since Z=0 after reset.
- Flag write then EQ:
  - Stimulus: Cond=1110, FlagW=11, ALUFlags=0100, one edge; then Cond=0000, RegW=1.
  - Response: RegWrite=1. Cond=0001 gives RegWrite=0.
- Partial write:
  - Stimulus: stored flags 0000; Cond=1110, FlagW=01, ALUFlags=1111, one edge.
  - Response: Flags=0011 (N,Z unchanged). Cond=0010 gives CondEx=1; Cond=0100 gives CondEx=0.
- Failed condition blocks flag write:
  - Stimulus: stored Z=0; Cond=0000, FlagW=11, ALUFlags=1111, PCS=1, MemW=1, one edge.
  - Response: PCSrc=0, MemWrite=0; Flags remain unchanged.
- Signed compares:
  - Stimulus: stored N=1, V=0.
  - Response: GE=0, LT=1, GT=0, LE=1.
  - Stimulus: stored N=1, V=1, Z=0.
  - Response: GE=1, GT=1, LE=0.
  - Stimulus: stored C=1, Z=0.
  - Response: HI=1, LS=0.
- Reset priority:
  - Stimulus: Reset=1 with Cond=1110, FlagW=11, ALUFlags=1111 on the same edge.
  - Response: Flags=0000 afterwards.
  - Stimulus: Cond=1111.
  - Response: CondEx=1.
